// File: rtl/vga_pkg.sv
// Shared timing constants, address types and helpers for the 640x480 monochrome framebuffer.
// The scan and address logic of the other modules uses these values.
package vga_pkg;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
   localparam int COORD_W  = 11;
   localparam int ADDR_W   = 19;
   localparam int CNT_W    = 10;

   typedef logic [ADDR_W-1:0] fb_addr_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic visible;
   } scan_flags_t;

   localparam scan_flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, visible: 1'b0};

   // row*640 built from two shifts, so no multiplier is needed
   function automatic fb_addr_t times_640(input fb_addr_t row);
      return (row << 9) + (row << 7);
   endfunction
endpackage

// File: rtl/vga_framebuffer_if.sv
// Pixel write port from the drawing engines together with the ADV7123 DAC pins.
// The engine side uses master and the framebuffer uses slave.
interface vga_framebuffer_if #(
   parameter int COORD_W = vga_pkg::COORD_W
);
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               pixel_color;
   logic               pixel_write;

   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_CLK;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_n;
   logic       VGA_SYNC_n;

   modport master (
      output x, y, pixel_color, pixel_write,
      input  VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
   );

   modport slave (
      input  x, y, pixel_color, pixel_write,
      output VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
   );
endinterface

// File: rtl/vga_timing.sv
// Derives the pixel clock and pixel enable from clk50 and runs the horizontal and
// vertical scan counters, which produce the unregistered hs, vs and visible flags.
module vga_timing #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input  logic                      clk50,
   input  logic                      reset,
   output logic                      pix_en,
   output logic                      vga_clk,
   output logic [vga_pkg::CNT_W-1:0] hcnt,
   output logic [vga_pkg::CNT_W-1:0] vcnt,
   output vga_pkg::scan_flags_t      flags
);
   import vga_pkg::*;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             clk_tgl_reg;
   logic [CNT_W-1:0] hcnt_reg;
   logic [CNT_W-1:0] vcnt_reg;

   // pix_en is high while the toggle is low, which is the cycle before VGA_CLK rises
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         clk_tgl_reg <= 1'b0;
      end else begin
         clk_tgl_reg <= ~clk_tgl_reg;
      end
   end

   assign pix_en  = ~clk_tgl_reg;
   assign vga_clk = clk_tgl_reg;

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else if (pix_en) begin
         if (hcnt_reg == H_LAST) begin
            hcnt_reg <= '0;
            vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
         end else begin
            hcnt_reg <= hcnt_reg + 1'b1;
         end
      end
   end

   assign hcnt = hcnt_reg;
   assign vcnt = vcnt_reg;

   always_comb begin
      flags         = FLAGS_IDLE;
      flags.visible = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
      flags.hs      = !((hcnt_reg >= HS_START) && (hcnt_reg < HS_END));
      flags.vs      = !((vcnt_reg >= VS_START) && (vcnt_reg < VS_END));
   end
endmodule

// File: rtl/vga_framebuffer.sv
// Monochrome framebuffer with a 1 bit per pixel RAM, written by the drawing engines and
// scanned out to the VGA DAC through a two-stage pixel pipeline.
module vga_framebuffer #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int COORD_W  = vga_pkg::COORD_W
) (
   input logic              clk50,
   input logic              reset,
   vga_framebuffer_if.slave vga
);
   import vga_pkg::*;

   localparam int                 DEPTH   = H_ACTIVE * V_ACTIVE;
   localparam int                 IDX_W   = $clog2(DEPTH);
   localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(V_ACTIVE);

   logic             pix_en;
   logic             vga_clk;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   scan_flags_t      flags;

   vga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk50  (clk50),
      .reset  (reset),
      .pix_en (pix_en),
      .vga_clk(vga_clk),
      .hcnt   (hcnt),
      .vcnt   (vcnt),
      .flags  (flags)
   );

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // Both coordinates are range checked before the write, so an oversized x cannot spill into the next row
   assign wr_en = vga.pixel_write && (vga.x < X_LIMIT) && (vga.y < Y_LIMIT);

   generate
      if (H_ACTIVE == 640) begin : g_row_shift
         assign wr_idx = IDX_W'(times_640(ADDR_W'(vga.y)) + ADDR_W'(vga.x));
         assign rd_idx = IDX_W'(times_640(ADDR_W'(vcnt)) + ADDR_W'(hcnt));
      end else begin : g_row_mult
         assign wr_idx = IDX_W'(vga.y) * IDX_W'(H_ACTIVE) + IDX_W'(vga.x);
         assign rd_idx = IDX_W'(vcnt) * IDX_W'(H_ACTIVE) + IDX_W'(hcnt);
      end
   endgenerate

   logic mem_reg [0:DEPTH-1];
   logic rd_data_reg;

   // The read returns the old data when it hits the address being written
   always_ff @(posedge clk50) begin
      if (wr_en) begin
         mem_reg[wr_idx] <= vga.pixel_color;
      end
      if (pix_en) begin
         rd_data_reg <= mem_reg[rd_idx];
      end
   end

   scan_flags_t flags_d1_reg;
   logic        hs_reg;
   logic        vs_reg;
   logic        blank_n_reg;
   logic [23:0] rgb_reg;

   // The flags take one stage to line up with the RAM read and a second in the output registers
   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         flags_d1_reg <= FLAGS_IDLE;
         hs_reg       <= 1'b1;
         vs_reg       <= 1'b1;
         blank_n_reg  <= 1'b0;
         rgb_reg      <= '0;
      end else if (pix_en) begin
         flags_d1_reg <= flags;
         hs_reg       <= flags_d1_reg.hs;
         vs_reg       <= flags_d1_reg.vs;
         blank_n_reg  <= flags_d1_reg.visible;
         rgb_reg      <= flags_d1_reg.visible ? {24{rd_data_reg}} : 24'h0;
      end
   end

   assign vga.VGA_CLK                     = vga_clk;
   assign vga.VGA_HS                      = hs_reg;
   assign vga.VGA_VS                      = vs_reg;
   assign vga.VGA_BLANK_n                 = blank_n_reg;
   assign {vga.VGA_R, vga.VGA_G, vga.VGA_B} = rgb_reg;
   assign vga.VGA_SYNC_n                  = 1'b0;
endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench: a full 640x480 instance for line timing and the first lines, and a
// shrunken 16x8 instance so whole frames, VS and mid-frame reset fit in a short run.
module tb_vga_framebuffer;
   localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 2;
   localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 1;

   logic        clk50 = 1'b0;
   logic        reset = 1'b1;
   int          errors = 0;
   int          checks = 0;
   int unsigned n;

   always #10 clk50 = ~clk50;

   // clk50 rising edges since the last reset release
   always @(posedge clk50 or negedge reset) begin
      if (!reset) n <= 0;
      else        n <= n + 1;
   end

   vga_framebuffer_if #(.COORD_W(11)) full_if ();
   vga_framebuffer_if #(.COORD_W(11)) small_if ();

   vga_framebuffer dut_full (
      .clk50(clk50),
      .reset(reset),
      .vga  (full_if.slave)
   );

   vga_framebuffer #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .COORD_W(11)
   ) dut_small (
      .clk50(clk50),
      .reset(reset),
      .vga  (small_if.slave)
   );

   function automatic logic [28:0] full_pins();
      return {full_if.VGA_CLK, full_if.VGA_HS, full_if.VGA_VS, full_if.VGA_BLANK_n,
              full_if.VGA_SYNC_n, full_if.VGA_R, full_if.VGA_G, full_if.VGA_B};
   endfunction

   function automatic logic [28:0] small_pins();
      return {small_if.VGA_CLK, small_if.VGA_HS, small_if.VGA_VS, small_if.VGA_BLANK_n,
              small_if.VGA_SYNC_n, small_if.VGA_R, small_if.VGA_G, small_if.VGA_B};
   endfunction

   task automatic wr(input bit to_small, input int xx, input int yy, input bit c);
      @(negedge clk50);
      full_if.pixel_write  = 1'b0;
      small_if.pixel_write = 1'b0;
      if (to_small) begin
         small_if.x = 11'(xx); small_if.y = 11'(yy);
         small_if.pixel_color = c; small_if.pixel_write = 1'b1;
      end else begin
         full_if.x = 11'(xx); full_if.y = 11'(yy);
         full_if.pixel_color = c; full_if.pixel_write = 1'b1;
      end
   endtask

   task automatic wr_idle();
      @(negedge clk50);
      full_if.pixel_write  = 1'b0;
      small_if.pixel_write = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk50);
      reset = 1'b0;
      repeat (2) @(negedge clk50);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      repeat (3) @(negedge clk50);
      checks++;
      if (full_pins() !== {5'b01100, 24'h0}) begin
         errors++;
         $display("FAIL reset_full: got %h, expected %h", full_pins(), {5'b01100, 24'h0});
      end
      checks++;
      if (small_pins() !== {5'b01100, 24'h0}) begin
         errors++;
         $display("FAIL reset_small: got %h, expected %h", small_pins(), {5'b01100, 24'h0});
      end
      $display("test_reset: done");
   endtask

   task automatic load_images();
      @(negedge clk50);
      reset = 1'b1;
      for (int yy = 0; yy <= 10; yy++)
         for (int xx = 0; xx < 640; xx++) wr(1'b0, xx, yy, 1'b0);
      wr(1'b0, 0, 0, 1'b1);
      wr(1'b0, 640, 0, 1'b1);     // would alias onto (0,1)
      wr(1'b0, 2047, 0, 1'b1);    // would alias onto (127,3)
      wr(1'b0, 0, 480, 1'b1);
      wr(1'b0, 10, 10, 1'b1);
      wr(1'b0, 10, 10, 1'b0);
      for (int yy = 0; yy < S_VA; yy++)
         for (int xx = 0; xx < S_HA; xx++) wr(1'b1, xx, yy, 1'b0);
      wr(1'b1, 0, 0, 1'b1);
      wr(1'b1, 15, 7, 1'b1);
      wr(1'b1, 16, 0, 1'b1);      // would alias onto (0,1)
      wr(1'b1, 20, 0, 1'b1);      // would alias onto (4,1)
      wr(1'b1, 0, 8, 1'b1);
      wr(1'b1, 3, 3, 1'b1);
      wr(1'b1, 3, 3, 1'b0);
      wr_idle();
      $display("load_images: done");
   endtask

   task automatic test_full_scan();
      int hs_fall1, hs_rise1, hs_fall2, p, h, v;
      logic hs_prev;
      logic [26:0] got, exp;
      hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1; hs_prev = 1'b1;
      do_reset();
      for (int k = 0; k < 16100; k++) begin
         @(negedge clk50);
         if (hs_prev && !full_if.VGA_HS) begin
            if (hs_fall1 < 0) hs_fall1 = int'(n);
            else if (hs_fall2 < 0) hs_fall2 = int'(n);
         end
         if (!hs_prev && full_if.VGA_HS && hs_rise1 < 0) hs_rise1 = int'(n);
         hs_prev = full_if.VGA_HS;
         if (n < 8) begin
            checks++;
            if ({full_if.VGA_CLK, full_if.VGA_SYNC_n} !== {n[0], 1'b0}) begin
               errors++;
               $display("FAIL full_pixclk n=%0d: clk/sync_n got %b%b, expected %b0",
                        n, full_if.VGA_CLK, full_if.VGA_SYNC_n, n[0]);
            end
         end
         if (n >= 3 && n[0]) begin
            p = (int'(n) - 3) / 2;
            h = p % 800;
            v = p / 800;
            exp = {(h < 640 && v < 480), !(h >= 656 && h < 752), 1'b1,
                   (h == 0 && v == 0) ? 24'hFFFFFF : 24'h0};
            got = {full_if.VGA_BLANK_n, full_if.VGA_HS, full_if.VGA_VS,
                   full_if.VGA_R, full_if.VGA_G, full_if.VGA_B};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL full_pixel(%0d,%0d): blank/hs/vs/rgb got %h, expected %h", h, v, got, exp);
            end
         end
      end
      checks++;
      if (hs_rise1 - hs_fall1 != 192) begin
         errors++;
         $display("FAIL full_hs_low: got %0d clk50, expected 192", hs_rise1 - hs_fall1);
      end
      checks++;
      if (hs_fall2 - hs_fall1 != 1600) begin
         errors++;
         $display("FAIL full_hs_period: got %0d clk50, expected 1600", hs_fall2 - hs_fall1);
      end
      $display("test_full_scan: hs fall at %0d, rise at %0d, next fall at %0d", hs_fall1, hs_rise1, hs_fall2);
   endtask

   task automatic test_small_frame();
      int vs_fall1, vs_rise1, vs_fall2, p, h, v;
      logic vs_prev;
      logic [26:0] got, exp;
      vs_fall1 = -1; vs_rise1 = -1; vs_fall2 = -1; vs_prev = 1'b1;
      do_reset();
      for (int k = 0; k < 1160; k++) begin
         @(negedge clk50);
         if (vs_prev && !small_if.VGA_VS) begin
            if (vs_fall1 < 0) vs_fall1 = int'(n);
            else if (vs_fall2 < 0) vs_fall2 = int'(n);
         end
         if (!vs_prev && small_if.VGA_VS && vs_rise1 < 0) vs_rise1 = int'(n);
         vs_prev = small_if.VGA_VS;
         if (n >= 3 && n[0] && n < 3 + 2 * 576) begin
            p = (int'(n) - 3) / 2;
            h = p % 24;
            v = (p / 24) % 12;
            exp = {(h < 16 && v < 8), !(h >= 18 && h < 22), !(v >= 9 && v < 11),
                   ((h == 0 && v == 0) || (h == 15 && v == 7)) ? 24'hFFFFFF : 24'h0};
            got = {small_if.VGA_BLANK_n, small_if.VGA_HS, small_if.VGA_VS,
                   small_if.VGA_R, small_if.VGA_G, small_if.VGA_B};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL small_pixel(%0d,%0d): blank/hs/vs/rgb got %h, expected %h", h, v, got, exp);
            end
         end
      end
      checks++;
      if (vs_rise1 - vs_fall1 != 96) begin
         errors++;
         $display("FAIL small_vs_low: got %0d clk50, expected 96", vs_rise1 - vs_fall1);
      end
      checks++;
      if (vs_fall2 - vs_fall1 != 576) begin
         errors++;
         $display("FAIL small_vs_period: got %0d clk50, expected 576", vs_fall2 - vs_fall1);
      end
      $display("test_small_frame: vs fall at %0d, rise at %0d, next fall at %0d", vs_fall1, vs_rise1, vs_fall2);
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int k = 0; k < 400 && n != 263; k++) @(negedge clk50);
      checks++;
      if (n != 263 || small_if.VGA_BLANK_n !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_reach(10,5): n=%0d blank=%b, expected n=263 blank=1", n, small_if.VGA_BLANK_n);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (small_pins() !== {5'b01100, 24'h0}) begin
         errors++;
         $display("FAIL mid_reset_async: got %h, expected %h", small_pins(), {5'b01100, 24'h0});
      end
      @(negedge clk50);
      reset = 1'b1;
      for (int k = 0; k < 10 && n != 3; k++) @(negedge clk50);
      checks++;
      if (n != 3 || {small_if.VGA_BLANK_n, small_if.VGA_R} !== 9'h1FF) begin
         errors++;
         $display("FAIL mid_reset_pixel(0,0): n=%0d blank/r got %b/%h, expected 1/ff at n=3",
                  n, small_if.VGA_BLANK_n, small_if.VGA_R);
      end
      repeat (2) @(negedge clk50);
      checks++;
      if ({small_if.VGA_BLANK_n, small_if.VGA_R} !== 9'h100) begin
         errors++;
         $display("FAIL mid_reset_pixel(1,0): blank/r got %b/%h, expected 1/00", small_if.VGA_BLANK_n, small_if.VGA_R);
      end
      for (int k = 0; k < 500 && n != 369; k++) @(negedge clk50);
      checks++;
      if (n != 369 || {small_if.VGA_BLANK_n, small_if.VGA_B} !== 9'h1FF) begin
         errors++;
         $display("FAIL mid_reset_pixel(15,7): n=%0d blank/b got %b/%h, expected 1/ff at n=369",
                  n, small_if.VGA_BLANK_n, small_if.VGA_B);
      end
      repeat (2) @(negedge clk50);
      checks++;
      if ({small_if.VGA_BLANK_n, small_if.VGA_G} !== 9'h000) begin
         errors++;
         $display("FAIL mid_reset_blanking(16,7): blank/g got %b/%h, expected 0/00", small_if.VGA_BLANK_n, small_if.VGA_G);
      end
      checks++;
      if ({full_if.VGA_SYNC_n, small_if.VGA_SYNC_n} !== 2'b00) begin
         errors++;
         $display("FAIL sync_n: got %b%b, expected 00", full_if.VGA_SYNC_n, small_if.VGA_SYNC_n);
      end
      $display("test_mid_reset: done");
   endtask

   initial begin
      full_if.x = '0;  full_if.y = '0;  full_if.pixel_color = 1'b0;  full_if.pixel_write = 1'b0;
      small_if.x = '0; small_if.y = '0; small_if.pixel_color = 1'b0; small_if.pixel_write = 1'b0;
      test_reset();
      load_images();
      test_full_scan();
      test_small_frame();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation still running at 3 ms, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
